// File: rtl/fifo_frame_writer.sv
// Write-domain frame producer: pushes {SOF_TAG,len} header, payload words and an
// XOR checksum trailer into a FIFO write port while honouring the FIFO full flag.
module fifo_frame_writer #(
    parameter int                            FIFO_WIDTH = 16,
    parameter int                            LEN_W      = 8,
    parameter logic [FIFO_WIDTH-LEN_W-1:0]   SOF_TAG    = 8'hA5,
    parameter int                            CNT_W      = 16
) (
    input  logic                  clk_a,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LEN_W-1:0]      len,
    input  logic [FIFO_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic                  full,
    output logic                  wen_a,
    output logic [FIFO_WIDTH-1:0] din_a,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_W-1:0]      frame_cnt
);

    typedef enum logic [1:0] {IDLE, HDR, PAY, TRL} state_t;

    state_t                state, state_next;
    logic [LEN_W-1:0]      len_q;
    logic [LEN_W-1:0]      remaining;
    logic [FIFO_WIDTH-1:0] csum;
    logic                  xfer;
    logic                  trl_write;

    assign xfer      = (state == PAY) && s_valid && !full;
    assign trl_write = (state == TRL) && !full;
    assign busy      = (state != IDLE);

    always_comb begin
        state_next = state;
        wen_a      = 1'b0;
        s_ready    = 1'b0;
        din_a      = '0;
        case (state)
            IDLE: begin
                if (start) state_next = HDR;
            end
            HDR: begin
                din_a = {SOF_TAG, len_q};
                wen_a = !full;
                if (!full) state_next = (len_q == '0) ? TRL : PAY;
            end
            PAY: begin
                din_a   = s_data;
                s_ready = !full;
                wen_a   = xfer;
                if (xfer && remaining == LEN_W'(1)) state_next = TRL;
            end
            TRL: begin
                din_a = csum;
                wen_a = !full;
                if (!full) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_a) begin
        if (rst) begin
            state     <= IDLE;
            len_q     <= '0;
            remaining <= '0;
            csum      <= '0;
            frame_cnt <= '0;
            done      <= 1'b0;
        end else begin
            state <= state_next;
            done  <= trl_write;
            if (state == IDLE && start) begin
                len_q     <= len;
                remaining <= len;
                csum      <= '0;
            end
            // remaining only decrements on a real transfer and PAY exits at 1, so it cannot wrap
            if (xfer) begin
                csum      <= csum ^ s_data;
                remaining <= remaining - LEN_W'(1);
            end
            if (trl_write) frame_cnt <= frame_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fifo_frame_writer.sv
// Self-checking bench for fifo_frame_writer: table vectors, hand-written corner
// sequences and randomized frames checked against a word-list frame model.
module tb_fifo_frame_writer;

    logic        clk_a = 1'b0;
    logic        rst, start, s_valid, s_ready, full, wen_a, busy, done;
    logic [7:0]  len;
    logic [15:0] s_data, din_a, frame_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int model_cnt = 0;

    always #5 clk_a = ~clk_a;

    fifo_frame_writer #(
        .FIFO_WIDTH(16),
        .LEN_W(8),
        .SOF_TAG(8'hA5),
        .CNT_W(16)
    ) dut (
        .clk_a(clk_a), .rst(rst), .start(start), .len(len),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .full(full), .wen_a(wen_a), .din_a(din_a),
        .busy(busy), .done(done), .frame_cnt(frame_cnt)
    );

    typedef struct {
        int          flen;
        logic [15:0] pay[6];
        int          fmode;   // 0 none, 1 random, 2 forced 3-cycle stall, 3 depth-8 FIFO model
        int          gmode;   // 0 always valid, 1 random, 2 toggling
        bit          pulse;
        logic [15:0] exp_trl;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_frame(input int len_v, input logic [15:0] words[$], input int fmode,
                             input int gmode, input bit hold, input int next_len,
                             input bit pulse, input bit use_trl, input logic [15:0] exp_trl);
        logic [15:0] exp_q[$];
        logic [15:0] got_q[$];
        logic [15:0] x;
        int idx, fifo_cnt, k, first_wr, last_wr, done_at, budget;
        bit saw_done, saw_ready, wrote;
        x = '0;
        exp_q.push_back({8'hA5, 8'(len_v)});
        foreach (words[i]) begin
            exp_q.push_back(words[i]);
            x ^= words[i];
        end
        exp_q.push_back(x);
        idx = 0; fifo_cnt = 0; k = 0; first_wr = -1; last_wr = -100; done_at = -1;
        saw_done = 0; saw_ready = 0;
        budget = 60 + 8 * len_v;
        @(posedge clk_a); #1;
        start   = 1'b1;
        len     = 8'(len_v);
        full    = 1'b0;
        s_valid = (gmode == 1) ? 1'($urandom_range(1)) : 1'b1;
        s_data  = (len_v > 0) ? words[0] : 16'($urandom);
        while (k < budget) begin
            @(negedge clk_a);
            if (full) begin
                check("stall_wen", {31'b0, wen_a}, 0);
                check("stall_ready", {31'b0, s_ready}, 0);
            end
            if (s_ready) saw_ready = 1;
            wrote = wen_a;
            if (wen_a) begin
                got_q.push_back(din_a);
                if (first_wr < 0) first_wr = k;
                last_wr = k;
            end
            if (s_valid && s_ready) idx++;
            if (done) begin
                saw_done = 1;
                done_at  = k;
                break;
            end
            @(posedge clk_a); #1;
            k++;
            if (!hold) start = pulse && (k == 3);
            if (hold && k == 1) len = 8'(next_len);
            case (fmode)
                1: full = ($urandom_range(99) < 30);
                2: full = (k >= 3 && k <= 5);
                3: begin
                    if (wrote) fifo_cnt++;
                    if (fifo_cnt > 0 && $urandom_range(3) == 0) fifo_cnt--;
                    full = (fifo_cnt >= 8);
                end
                default: full = 1'b0;
            endcase
            case (gmode)
                1: s_valid = 1'($urandom_range(1));
                2: s_valid = (k % 2 == 0);
                default: s_valid = 1'b1;
            endcase
            s_data = (idx < len_v) ? words[idx] : 16'($urandom);
        end
        if (!hold) start = 1'b0;
        full = 1'b0;
        s_valid = 1'b0;
        check("done_seen", {31'b0, saw_done}, 1);
        check("word_count", got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check($sformatf("word%0d", i), got_q[i], exp_q[i]);
        if (use_trl && got_q.size() > 0) check("trailer", got_q[got_q.size()-1], exp_trl);
        check("done_latency", done_at, last_wr + 1);
        model_cnt++;
        check("frame_cnt", frame_cnt, 32'(16'(model_cnt)));
        if (len_v == 0) check("ready_len0", {31'b0, saw_ready}, 0);
        if (fmode == 0 && gmode == 0) check("burst", last_wr - first_wr, len_v + 1);
    endtask

    vec_t        vecs[6];
    logic [15:0] wq[$];
    int          acc, rl, fm;

    initial begin
        vecs[0] = '{3, '{16'h1111, 16'h2222, 16'h4444, 0, 0, 0}, 0, 0, 0, 16'h7777};
        vecs[1] = '{0, '{0, 0, 0, 0, 0, 0}, 0, 0, 0, 16'h0000};
        vecs[2] = '{4, '{16'h0001, 16'h0010, 16'h0100, 16'h1000, 0, 0}, 2, 0, 0, 16'h1111};
        vecs[3] = '{5, '{16'h00FF, 16'hFF00, 16'h0F0F, 16'hF0F0, 16'h1234, 0}, 0, 2, 0, 16'h1234};
        vecs[4] = '{6, '{16'hAAAA, 16'h5555, 16'h0001, 16'h0002, 16'h0004, 16'h8000}, 1, 1, 1, 16'h7FF8};
        vecs[5] = '{2, '{16'hDEAD, 16'hBEEF, 0, 0, 0, 0}, 0, 0, 1, 16'h6042};

        rst = 1'b1; start = 1'b0; len = '0; s_data = '0; s_valid = 1'b0; full = 1'b0;
        repeat (2) @(posedge clk_a);
        @(negedge clk_a);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_wen", {31'b0, wen_a}, 0);
        check("rst_ready", {31'b0, s_ready}, 0);
        check("rst_done", {31'b0, done}, 0);
        check("rst_din", din_a, 0);
        check("rst_cnt", frame_cnt, 0);
        @(posedge clk_a); #1;
        rst = 1'b0;

        for (int v = 0; v < 6; v++) begin
            wq.delete();
            for (int i = 0; i < vecs[v].flen; i++) wq.push_back(vecs[v].pay[i]);
            run_frame(vecs[v].flen, wq, vecs[v].fmode, vecs[v].gmode, 0, 0,
                      vecs[v].pulse, 1, vecs[v].exp_trl);
        end

        // start held across the end of one frame launches exactly one more
        wq.delete(); wq.push_back(16'h0A0A); wq.push_back(16'h0B0B);
        run_frame(2, wq, 0, 0, 1, 3, 0, 1, 16'h0101);
        wq.delete(); wq.push_back(16'h1000); wq.push_back(16'h0200); wq.push_back(16'h0030);
        run_frame(3, wq, 0, 0, 0, 0, 0, 1, 16'h1230);
        repeat (3) @(posedge clk_a);
        @(negedge clk_a);
        check("idle_after_hold", {31'b0, busy}, 0);
        check("cnt_after_hold", frame_cnt, 32'(16'(model_cnt)));

        // reset after the second payload word of a len=6 frame
        @(posedge clk_a); #1;
        start = 1'b1; len = 8'd6; s_valid = 1'b1; s_data = 16'h3C3C;
        @(posedge clk_a); #1;
        start = 1'b0;
        acc = 0;
        for (int c = 0; c < 20 && acc < 2; c++) begin
            @(negedge clk_a);
            if (s_valid && s_ready) acc++;
            if (acc < 2) begin @(posedge clk_a); #1; end
        end
        check("rst_mid_reached", acc, 2);
        @(posedge clk_a); #1;
        rst = 1'b1;
        @(posedge clk_a); #1;
        rst = 1'b0; s_valid = 1'b0;
        @(negedge clk_a);
        check("midrst_busy", {31'b0, busy}, 0);
        check("midrst_wen", {31'b0, wen_a}, 0);
        check("midrst_ready", {31'b0, s_ready}, 0);
        check("midrst_din", din_a, 0);
        check("midrst_cnt", frame_cnt, 0);
        model_cnt = 0;
        wq.delete(); wq.push_back(16'h5A5A);
        run_frame(1, wq, 0, 0, 0, 0, 0, 1, 16'h5A5A);

        // depth-8 FIFO with slow reader
        wq.delete();
        for (int i = 0; i < 10; i++) wq.push_back(16'(16'h0100 + i));
        run_frame(10, wq, 3, 0, 0, 0, 0, 0, '0);

        // maximum length
        wq.delete();
        for (int i = 0; i < 255; i++) wq.push_back(16'($urandom));
        run_frame(255, wq, 1, 1, 0, 0, 0, 0, '0);

        for (int f = 0; f < 12; f++) begin
            rl = $urandom_range(0, 20);
            wq.delete();
            for (int i = 0; i < rl; i++) wq.push_back(16'($urandom));
            fm = $urandom_range(0, 2);
            if (fm == 2) fm = 3;
            run_frame(rl, wq, fm, $urandom_range(0, 1), 0, 0, (rl >= 2) && f[0], 0, '0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

endmodule
